// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encoding, frame width and baud timing helpers.
package uart_rx_core_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   // Clock cycles per bit, rounded to nearest.
   function automatic int calc_bit_cnt(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

   function automatic int calc_half_cnt(input int clk_freq, input int baud);
      return calc_bit_cnt(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_core_sync_fifo.sv
// First-word fall-through FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // A simultaneous pop frees the slot, so a write into a full FIFO is still accepted.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling FSM, byte FIFO on a valid/ready read port,
// one-cycle framing error pulse and sticky overrun flag.
module uart_rx_core
   import uart_rx_core_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       err_clr,
   output logic       busy
);

   localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
   localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
   localparam int CW       = $clog2(BIT_CNT);

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 rx_meta_q, rx_meta_d;
   logic                 rx_s_q, rx_s_d;
   logic [1:0]           sync_ok_q, sync_ok_d;
   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 armed_q, armed_d;
   logic                 push_q, push_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;

   assign rx_meta_d = rx;
   assign rx_s_d    = rx_meta_q;
   // Marks when rx_s_q reflects the real line rather than the synchronizer reset value.
   assign sync_ok_d = {sync_ok_q[0], 1'b1};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      armed_d     = armed_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A start is only accepted after the line has been seen high, so a stuck-low
            // line cannot retrigger the receiver every cycle.
            if (sync_ok_q[1] && rx_s_q) begin
               armed_d = 1'b1;
            end
            if (armed_q && !rx_s_q) begin
               state_d = ST_START;
               cnt_d   = '0;
               armed_d = 1'b0;
            end
         end

         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = ST_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
               if (bit_idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rx_s_q) begin
                  push_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign fifo_pop = rd_ready & ~fifo_empty;

   // Set has priority over clear; a full FIFO that is popped this cycle still takes the byte.
   always_comb begin
      overrun_d = overrun_q;
      if (push_q && fifo_full && !fifo_pop) begin
         overrun_d = 1'b1;
      end else if (err_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         sync_ok_q   <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         armed_q     <= 1'b0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         sync_ok_q   <= sync_ok_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         armed_q     <= armed_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_q),
      .wr_data (shreg_q),
      .full    (fifo_full),
      .rd_en   (rd_ready),
      .rd_data (rd_data),
      .empty   (fifo_empty)
   );

   assign rd_valid  = ~fifo_empty;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit (1.8432 MHz clock, 115200 baud).
module tb_uart_rx_core;

   localparam int CLK_FREQ = 1843200;
   localparam int BAUD     = 115200;
   localparam int BIT      = 16;
   localparam int HALF     = 8;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       frame_err;
   logic       overrun;
   logic       err_clr;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] log_mem [0:255];
   int         log_n      = 0;
   int         fe_pulses  = 0;
   int         fe_run     = 0;
   int         fe_max_run = 0;

   uart_rx_core #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every accepted pop and the shape of frame_err pulses.
   always @(negedge clk) begin
      #1;
      if (rd_valid && rd_ready && !rst) begin
         log_mem[log_n[7:0]] = rd_data;
         log_n = log_n + 1;
      end
      if (frame_err) begin
         if (fe_run == 0) fe_pulses = fe_pulses + 1;
         fe_run = fe_run + 1;
         if (fe_run > fe_max_run) fe_max_run = fe_run;
      end else begin
         fe_run = 0;
      end
   end

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 100000 cycles, required to finish earlier");
      $fatal(1, "watchdog expired");
   end

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop_val;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      idle_bits(2);
   endtask

   task automatic test_single;
      int base;
      int fe0;
      base = log_n; fe0 = fe_pulses;
      rd_ready = 1'b1;
      fork
         send_byte(8'h55, 1'b1);
         begin
            repeat (3 * BIT) @(negedge clk);
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b want 1", busy); end
         end
      join
      idle_bits(1);
      n_cmp++; if (log_n - base !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", log_n - base); end
      n_cmp++; if (log_mem[base[7:0]] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h want 55", log_mem[base[7:0]]); end
      n_cmp++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_pulses - fe0); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b want 0", overrun); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back;
      int base;
      logic [7:0] exp_b [3];
      exp_b[0] = 8'hA5; exp_b[1] = 8'h0F; exp_b[2] = 8'hFF;
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
      idle_bits(1);
      #1;
      n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rd_valid); end
      n_cmp++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL b2b_head: got %h want a5", rd_data); end
      base = log_n;
      @(negedge clk);
      rd_ready = 1'b1;
      repeat (6) @(negedge clk);
      rd_ready = 1'b0;
      #2;
      n_cmp++; if (log_n - base !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", log_n - base); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (log_mem[(base + i) & 255] !== exp_b[i]) begin
            n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", i, log_mem[(base + i) & 255], exp_b[i]);
         end
      end
      n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", rd_valid); end
   endtask

   task automatic test_glitch;
      int base;
      int fe0;
      base = log_n; fe0 = fe_pulses;
      rd_ready = 1'b1;
      rx = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
      idle_bits(2);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
      n_cmp++; if (log_n - base !== 0) begin n_fail++; $display("FAIL glitch_push: got %0d bytes want 0", log_n - base); end
      n_cmp++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d want 0", fe_pulses - fe0); end
   endtask

   task automatic test_frame_err;
      int base;
      int fe0;
      base = log_n; fe0 = fe_pulses;
      rd_ready = 1'b1;
      send_byte(8'h3C, 1'b0);
      idle_bits(2);
      n_cmp++; if (fe_pulses - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_pulses - fe0); end
      n_cmp++; if (fe_max_run !== 1) begin n_fail++; $display("FAIL ferr_width: got %0d cycles want 1", fe_max_run); end
      n_cmp++; if (log_n - base !== 0) begin n_fail++; $display("FAIL ferr_discard: got %0d bytes want 0", log_n - base); end
      send_byte(8'h3C, 1'b1);
      idle_bits(1);
      n_cmp++; if (log_n - base !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d want 1", log_n - base); end
      n_cmp++; if (log_mem[base[7:0]] !== 8'h3C) begin n_fail++; $display("FAIL ferr_recover_data: got %h want 3c", log_mem[base[7:0]]); end
   endtask

   task automatic test_overrun;
      int base;
      logic [7:0] b;
      rd_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         b = 8'(i);
         send_byte(b, 1'b1);
         idle_bits(2);
      end
      #1;
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
      n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL ovr_head: got %h want 00", rd_data); end
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
      base = log_n;
      @(negedge clk);
      rd_ready = 1'b1;
      repeat (20) @(negedge clk);
      rd_ready = 1'b0;
      #2;
      n_cmp++; if (log_n - base !== 16) begin n_fail++; $display("FAIL ovr_count: got %0d want 16", log_n - base); end
      for (int i = 0; i < 16; i++) begin
         b = 8'(i);
         n_cmp++;
         if (log_mem[(base + i) & 255] !== b) begin
            n_fail++; $display("FAIL ovr_entry[%0d]: got %h want %h", i, log_mem[(base + i) & 255], b);
         end
      end
   endtask

   task automatic test_reset_mid;
      int base;
      rd_ready = 1'b0;
      send_byte(8'h99, 1'b1);
      idle_bits(2);
      fork
         send_byte(8'h81, 1'b1);
         begin
            repeat (5 * BIT + HALF) @(negedge clk);
            #1;
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
            n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_before: got %b want 1", rd_valid); end
            rst = 1'b1;
            #1;
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
            n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rd_valid); end
            repeat (3) @(negedge clk);
            rst = 1'b0;
         end
      join
      idle_bits(2);
      n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_partial: got %b want 0", rd_valid); end
      send_byte(8'h42, 1'b1);
      idle_bits(1);
      base = log_n;
      rd_ready = 1'b1;
      repeat (4) @(negedge clk);
      #2;
      n_cmp++; if (log_n - base !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", log_n - base); end
      n_cmp++; if (log_mem[base[7:0]] !== 8'h42) begin n_fail++; $display("FAIL rstmid_data: got %h want 42", log_mem[base[7:0]]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
